c432_campaign_ctrl: RTL and testbench
=====================================

# c432_campaign_ctrl

Sequencer for fault-injection campaigns on the registered c432 benchmark wrapper. It streams pseudo-random 36-bit vectors into two wrapper instances in lock-step, a golden copy and a fault-injected copy. It compares their 7-bit outputs after the fixed wrapper latency and counts mismatching vectors. The host starts a run, waits for `done`, then reads the error count, the index of the first failing vector and that vector's syndrome.

## Interface
- `IN_W`, 36: vector width; equals the wrapper input width.
- `OUT_W`, 7: compared output width.
- `CNT_W`, 32: width of the vector-count and error-count fields.
- `LAT`, 2: cycles from `vec_out` change to the matching wrapper output; the wrapper has an input flop and an output flop.

Ports:
- `clk` in 1: single clock, shared with both wrappers.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle run request; sampled only in IDLE.
- `num_vectors` in CNT_W: number of vectors to apply; sampled with `start`.
- `seed` in IN_W: LFSR seed; sampled with `start`. A zero seed is replaced by 1.
- `vec_out` out IN_W: stimulus to both wrappers. Bit i drives wrapper `in[i]`.
- `fault_en` out 1: enables the fault injector. High in RUN and DRAIN.
- `golden_in` in OUT_W: golden wrapper `out`.
- `faulty_in` in OUT_W: faulty wrapper `out`.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse in DONE.
- `err_count` out CNT_W: number of mismatching vectors; saturates at all-ones.
- `first_err_idx` out CNT_W: index of the first mismatching vector. All-ones if there was no mismatch.
- `first_err_syn` out OUT_W: `golden_in ^ faulty_in` of the first mismatch.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE with `start`=1:
  - Load the LFSR from `seed`; a zero seed loads 1.
  - Clear `vec_cnt`, `err_count` and `first_err_syn`.
  - Set `first_err_idx` to all-ones and latch `num_vectors`.
  - Go to RUN, or go directly to DONE if `num_vectors`==0.
- RUN, each cycle:
  - `vec_out` holds the current LFSR value as vector `vec_cnt`.
  - Push `valid=1` and the index into a LAT-deep tag pipe.
  - Advance the LFSR and increment `vec_cnt`.
  - When the vector with index `num_vectors`-1 is issued, go to DRAIN.
- LFSR step: `next = {v[IN_W-2:0], v[35]^v[24]}` (x^36+x^25+1).
- `vec_out` holds its last value outside RUN.
- DRAIN:
  - Push `valid=0` into the tag pipe.
  - After LAT cycles, go to DONE.
- DONE: assert `done` for one cycle, then go to IDLE.
- Compare, every cycle in which the tag pipe output is valid:
  - A mismatch is `golden_in != faulty_in`.
  - On a mismatch, `err_count` increments, saturating at all-ones.
  - On the first mismatch of a run, also capture the tag into `first_err_idx` and the XOR into `first_err_syn`.
- `start` is ignored while `busy` or `done` is high.
- Result registers hold their values in IDLE until the next accepted `start`.
- `rst_n` low at any time, including mid-run, forces:
  - IDLE;
  - `vec_out`=0, `fault_en`=0, `busy`=0, `done`=0;
  - `err_count`=0, `first_err_idx`=all-ones, `first_err_syn`=0;
  - tag pipe cleared.

## Timing
- Cycle numbering: edge E0 samples `start`. Cycle c is the interval after edge Ec.
- Vector k is on `vec_out` in cycle k+1, for k=0..N-1.
- `busy` and `fault_en` are high in cycles 1..N+LAT.
- Vector k's outputs are compared in cycle k+1+LAT. The counters update at the end of that cycle.
- `done` is high in cycle N+LAT+1, and all results are final then.
- With N=0, `done` is high in cycle 1 and `busy` never rises.
- Run length is N+LAT+1 cycles from the `start` edge to the `done` cycle.
- A new `start` is accepted in cycle N+LAT+2 at the earliest.

## Test plan
- Identical outputs: seed=1, N=8, `golden_in`=`faulty_in` -> `vec_out`=1,2,4,…,0x80 in cycles 1..8; `done` in cycle 11; `err_count`=0; `first_err_idx`=0xFFFFFFFF.
- LFSR feedback: seed=1, N=27 -> vector 24 = 0x1000000, vector 25 = 0x2000001, vector 26 = 0x4000002.
- Single injected mismatch: force `faulty_in`=`golden_in`^7'h05 only in cycle 6, with N=8 -> `err_count`=1, `first_err_idx`=3, `first_err_syn`=7'h05.
- Persistent mismatch: `faulty_in`=~`golden_in` in all cycles, N=100 -> `err_count`=100, `first_err_idx`=0, `first_err_syn`=7'h7F. Then start a new run with equal outputs, N=5 -> `err_count`=0.
- Edge requests: N=0 -> `done` in cycle 1, `err_count`=0. A seed of 0 behaves exactly like seed=1. A `start` pulse in cycle 3 of an N=10 run is ignored and `done` stays at cycle 13.
- Reset mid-run: drop `rst_n` in cycle 5 of an N=20 run -> `busy`, `fault_en` and `vec_out` are 0 immediately; `err_count`=0. After release, a new run with N=4 completes normally with `done` in cycle 7.

Source files
------------

// File: rtl/c432_campaign_ctrl.sv
// Fault-injection campaign sequencer for the registered c432 wrapper.
// Streams LFSR vectors to golden/faulty copies and tallies output mismatches.
module c432_campaign_ctrl #(
    parameter int IN_W  = 36,
    parameter int OUT_W = 7,
    parameter int CNT_W = 32,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic [IN_W-1:0]  seed,
    output logic [IN_W-1:0]  vec_out,
    output logic             fault_en,
    input  logic [OUT_W-1:0] golden_in,
    input  logic [OUT_W-1:0] faulty_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [OUT_W-1:0] first_err_syn
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                      state_q, state_d;
    logic [IN_W-1:0]             vec_q, vec_d;
    logic [CNT_W-1:0]            vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0]            num_q, num_d;
    logic [7:0]                  drn_q, drn_d;
    logic [LAT-1:0]              tv_q, tv_d;
    logic [LAT-1:0][CNT_W-1:0]   ti_q, ti_d;
    logic [CNT_W-1:0]            err_q, err_d;
    logic [CNT_W-1:0]            fidx_q, fidx_d;
    logic [OUT_W-1:0]            fsyn_q, fsyn_d;

    logic accept;
    logic last_vec;
    logic [OUT_W-1:0] syn;

    assign accept   = (state_q == S_IDLE) && start;
    assign last_vec = (vec_cnt_q == num_q - CNT_W'(1));
    assign syn      = golden_in ^ faulty_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = (num_vectors == '0) ? S_DONE : S_RUN;
            S_RUN:   if (last_vec) state_d = S_DRAIN;
            S_DRAIN: if (drn_q == 8'(LAT - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN) || (state_q == S_DRAIN);
        fault_en = busy;
        done = (state_q == S_DONE);
    end

    always_comb begin
        vec_d     = vec_q;
        vec_cnt_d = vec_cnt_q;
        num_d     = num_q;
        drn_d     = drn_q;
        err_d     = err_q;
        fidx_d    = fidx_q;
        fsyn_d    = fsyn_q;
        tv_d[0]   = (state_q == S_RUN);
        ti_d[0]   = vec_cnt_q;
        for (int i = 1; i < LAT; i++) begin
            tv_d[i] = tv_q[i-1];
            ti_d[i] = ti_q[i-1];
        end
        if (tv_q[LAT-1] && (golden_in != faulty_in)) begin
            if (err_q != '1) err_d = err_q + CNT_W'(1);
            if (err_q == '0) begin
                fidx_d = ti_q[LAT-1];
                fsyn_d = syn;
            end
        end
        if (state_q == S_RUN) begin
            vec_cnt_d = vec_cnt_q + CNT_W'(1);
            drn_d     = '0;
            // The final vector stays on vec_out through DRAIN and IDLE.
            if (!last_vec) vec_d = {vec_q[IN_W-2:0], vec_q[IN_W-1] ^ vec_q[24]};
        end
        if (state_q == S_DRAIN) drn_d = drn_q + 8'd1;
        if (accept) begin
            vec_cnt_d = '0;
            num_d     = num_vectors;
            err_d     = '0;
            fidx_d    = '1;
            fsyn_d    = '0;
            if (num_vectors != '0) vec_d = (seed == '0) ? IN_W'(1) : seed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q     <= '0;
            vec_cnt_q <= '0;
            num_q     <= '0;
            drn_q     <= '0;
            tv_q      <= '0;
            ti_q      <= '0;
            err_q     <= '0;
            fidx_q    <= '1;
            fsyn_q    <= '0;
        end else begin
            vec_q     <= vec_d;
            vec_cnt_q <= vec_cnt_d;
            num_q     <= num_d;
            drn_q     <= drn_d;
            tv_q      <= tv_d;
            ti_q      <= ti_d;
            err_q     <= err_d;
            fidx_q    <= fidx_d;
            fsyn_q    <= fsyn_d;
        end
    end

    assign vec_out       = vec_q;
    assign err_count     = err_q;
    assign first_err_idx = fidx_q;
    assign first_err_syn = fsyn_q;

endmodule

// File: tb/tb_c432_campaign_ctrl.sv
// Directed bench for c432_campaign_ctrl: runs campaigns with
// hand-computed vectors, timing and error results.
module tb_c432_campaign_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] num_vectors = '0;
    logic [35:0] seed = '0;
    logic [35:0] vec_out;
    logic        fault_en;
    logic [6:0]  golden_in = '0;
    logic [6:0]  faulty_in = '0;
    logic        busy;
    logic        done;
    logic [31:0] err_count;
    logic [31:0] first_err_idx;
    logic [6:0]  first_err_syn;

    int n_chk = 0;
    int n_err = 0;
    logic [35:0] vo [0:127];
    logic [35:0] ref_vo [0:127];
    int dc;

    c432_campaign_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .num_vectors(num_vectors), .seed(seed), .vec_out(vec_out),
        .fault_en(fault_en), .golden_in(golden_in), .faulty_in(faulty_in),
        .busy(busy), .done(done), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_syn(first_err_syn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: equal outputs, 1: xor 5 in cycle inj, 2: inverted always
    task automatic do_run(input logic [35:0] sd, input int n, input int mode,
                          input int inj, input int stray, output int done_cyc);
        logic bexp;
        int bad_busy;
        bad_busy = 0;
        done_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        seed = sd;
        num_vectors = n;
        @(posedge clk);
        for (int c = 1; c <= n + 6 && done_cyc < 0; c++) begin
            @(negedge clk);
            start = (c == stray);
            if (c < 128) vo[c] = vec_out;
            golden_in = vec_out[6:0] ^ 7'(c);
            faulty_in = golden_in;
            if (mode == 1 && c == inj) faulty_in = golden_in ^ 7'h05;
            if (mode == 2) faulty_in = ~golden_in;
            bexp = (n != 0) && (c <= n + 2);
            if (busy !== bexp || fault_en !== bexp) bad_busy++;
            if (done) done_cyc = c;
        end
        start = 1'b0;
        golden_in = '0;
        faulty_in = '0;
        chk("busy_fault_en_window", 64'(bad_busy), 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vec_out", 64'(vec_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_fidx", 64'(first_err_idx), 64'hFFFFFFFF);
        chk("rst_fsyn", 64'(first_err_syn), 64'd0);
        rst_n = 1'b1;

        do_run(36'd1, 8, 0, 0, 0, dc);
        for (int k = 0; k < 8; k++) chk("vec_shift", 64'(vo[k+1]), 64'd1 << k);
        chk("vec_hold_drain", 64'(vo[10]), 64'h80);
        chk("done_n8", 64'(dc), 64'd11);
        chk("err_n8", 64'(err_count), 64'd0);
        chk("fidx_n8", 64'(first_err_idx), 64'hFFFFFFFF);
        for (int k = 1; k <= 8; k++) ref_vo[k] = vo[k];

        do_run(36'd1, 27, 0, 0, 0, dc);
        chk("lfsr_v24", 64'(vo[25]), 64'h1000000);
        chk("lfsr_v25", 64'(vo[26]), 64'h2000001);
        chk("lfsr_v26", 64'(vo[27]), 64'h4000002);
        chk("done_n27", 64'(dc), 64'd30);

        do_run(36'd1, 8, 1, 6, 0, dc);
        chk("inj_err", 64'(err_count), 64'd1);
        chk("inj_fidx", 64'(first_err_idx), 64'd3);
        chk("inj_fsyn", 64'(first_err_syn), 64'h05);
        chk("inj_done", 64'(dc), 64'd11);

        do_run(36'h123456789, 100, 2, 0, 0, dc);
        chk("pers_err", 64'(err_count), 64'd100);
        chk("pers_fidx", 64'(first_err_idx), 64'd0);
        chk("pers_fsyn", 64'(first_err_syn), 64'h7F);
        chk("pers_done", 64'(dc), 64'd103);
        repeat (3) @(negedge clk);
        chk("hold_err_idle", 64'(err_count), 64'd100);

        do_run(36'd7, 5, 0, 0, 0, dc);
        chk("rerun_err", 64'(err_count), 64'd0);
        chk("rerun_fidx", 64'(first_err_idx), 64'hFFFFFFFF);

        do_run(36'd1, 0, 2, 0, 0, dc);
        chk("n0_done", 64'(dc), 64'd1);
        chk("n0_err", 64'(err_count), 64'd0);

        do_run(36'd0, 8, 0, 0, 0, dc);
        for (int k = 1; k <= 8; k++) chk("seed0_vec", 64'(vo[k]), 64'(ref_vo[k]));
        chk("seed0_done", 64'(dc), 64'd11);

        do_run(36'd5, 10, 0, 0, 3, dc);
        chk("stray_start_done", 64'(dc), 64'd13);
        @(negedge clk);
        chk("stray_start_idle", 64'(busy), 64'd0);

        @(negedge clk);
        start = 1'b1;
        seed = 36'd9;
        num_vectors = 20;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        golden_in = 7'h11;
        faulty_in = 7'h22;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_fault_en", 64'(fault_en), 64'd0);
        chk("mrst_vec_out", 64'(vec_out), 64'd0);
        chk("mrst_err", 64'(err_count), 64'd0);
        chk("mrst_fidx", 64'(first_err_idx), 64'hFFFFFFFF);
        golden_in = '0;
        faulty_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_run(36'd1, 4, 0, 0, 0, dc);
        chk("mrst_after_done", 64'(dc), 64'd7);
        chk("mrst_after_err", 64'(err_count), 64'd0);
        chk("mrst_after_v3", 64'(vo[4]), 64'd8);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
